jnt_step_gen: RTL and testbench
===============================

Name: jnt_step_gen

Overview:
- Upstream feeder of the forward-kinematics stage.
- Accepts absolute 3-joint target angles and tracks the current commanded angles.
- Emits a stream of per-joint angle increments (jnt_int_0..2 format), each clamped to a maximum step, over a valid/ready handshake.
- Angles are 32-bit phase words (2^32 = full turn); every increment takes the shortest path around the circle.

Parameters:
- MAX_STEP, 32'h0100_0000, maximum |increment| per joint per step (unsigned, must be ≥1 and ≤ 2^31-1).
- INIT_JNT0, 0, reset value of cur_jnt_0.
- INIT_JNT1, 0, reset value of cur_jnt_1.
- INIT_JNT2, 0, reset value of cur_jnt_2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- tgt_valid  in  1  target triplet present.
- tgt_ready  out  1  block accepts a target.
- tgt_jnt_0 / tgt_jnt_1 / tgt_jnt_2  in  32 each  absolute target angles.
- step_valid  out  1  increment triplet present.
- step_ready  in  1  downstream accepts the increment.
- step_jnt_0 / step_jnt_1 / step_jnt_2  out  32 each  two's-complement increments.
- cur_jnt_0 / cur_jnt_1 / cur_jnt_2  out  32 each  current commanded angles.
- abort  in  1  cancel the move in progress.
- busy  out  1  move in progress.
- done  out  1  one-cycle pulse when the move completes.

Behaviour:
- Reset (synchronous, active-high, single clk edge):
  - state = IDLE; cur_jnt_n = INIT_JNTn.
  - tgt_ready = 1; step_valid = 0; step_jnt_n = 0; busy = 0; done = 0; latched targets = 0.
  - Reset mid-move discards the move with no further step.
- Per-joint diff (mod 2^32 subtraction, signed result): diff = tgt - cur. 32'h8000_0000 is read as -2^31.
- Clamp: step = +MAX_STEP if diff > MAX_STEP; -MAX_STEP if diff < -MAX_STEP; otherwise diff.
- States:
  - IDLE: tgt_ready = 1, busy = 0. On tgt_valid & tgt_ready, latch targets -> CALC.
  - CALC (1 cycle): busy = 1, tgt_ready = 0. Compute the three clamped steps.
    - All three zero -> DONE.
    - Otherwise register the steps into step_jnt_n -> EMIT.
  - EMIT: step_valid = 1. step_jnt_n is held stable until step_ready.
    - On the handshake, cur_jnt_n += step_jnt_n (mod 2^32) -> CALC.
  - DONE: done = 1 for one cycle -> IDLE.
- Latency: target accepted at edge T; first step_valid is high in the cycle after edge T+1. A zero move gives done high in that same cycle.
- Throughput: at most one step every 2 cycles (CALC/EMIT alternate).
- Abort, sampled in CALC or EMIT:
  - Go to IDLE, step_valid = 0, no done pulse.
  - If step handshake and abort occur together, the step is committed to cur first, then IDLE.
  - Abort is ignored in IDLE and DONE.
- step_valid never drops without a handshake, except on abort or reset.
- tgt_valid is ignored while busy; targets are not queued.

Optional Feature:
- Macro STEP_CNT_EN.
- Defined:
  - Adds output step_cnt [15:0].
  - Cleared when a target is accepted; +1 per step handshake; saturates at 16'hFFFF.
  - Holds its value in IDLE; reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package jnt_pkg:
  - ANGLE_W = 32; angle_t (32-bit unsigned) and delta_t (32-bit signed) typedefs.
  - DEFAULT_MAX_STEP constant.
  - State enum {IDLE, CALC, EMIT, DONE}.
- Sub-module jnt_step_clamp: combinational, one joint, computes diff and clamp. Instantiated 3 times.
- FSM, registers, handshake and the optional counter stay in the top module.

Test Plan (MAX_STEP = 32'h0100_0000 unless noted):
- Reset: all outputs at their reset values; cur_jnt = INIT values; tgt_ready = 1.
- Target (0x0300_0000, 0, 0) with step_ready = 1:
  - Three steps of (0x0100_0000, 0, 0), each spaced 2 cycles.
  - done pulse; cur_jnt_0 = 0x0300_0000.
  - step_cnt = 3 when STEP_CNT_EN is defined.
- Wrap from cur = 0:
  - Target (0xFF00_0000, 0x0080_0000, 0x8000_0000): first step = (0xFF00_0000, 0x0080_0000, 0xFF00_0000).
  - Joint 2 then takes 127 more -MAX_STEP steps.
- Backpressure: step_ready held low for 5 cycles -> step_valid stays 1, step_jnt stable, cur unchanged; step is committed on the cycle ready rises.
- Abort:
  - Asserted in EMIT with step_ready = 0 -> IDLE next cycle, step_valid = 0, no done, cur unchanged.
  - Repeat with step_ready = 1 -> step committed, then IDLE.
- Zero move: target equal to cur -> done high in the cycle after edge T+1, no step_valid; tgt_valid during busy is not accepted.

Source files
------------

// File: rtl/jnt_pkg.sv
// Shared types and constants for the joint step generator: angle/delta words,
// the default per-step clamp and the sequencer state encoding.
package jnt_pkg;

  localparam int ANGLE_W = 32;

  typedef logic        [ANGLE_W-1:0] angle_t;
  typedef logic signed [ANGLE_W-1:0] delta_t;

  localparam angle_t DEFAULT_MAX_STEP = 32'h0100_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/jnt_step_clamp.sv
// One joint: shortest-path signed difference between target and current phase
// words, clamped to +/-MAX_STEP. Purely combinational.
module jnt_step_clamp
  import jnt_pkg::*;
#(
  parameter logic [31:0] MAX_STEP = DEFAULT_MAX_STEP
) (
  input  logic [31:0] tgt,
  input  logic [31:0] cur,
  output logic [31:0] step
);

  delta_t diff;
  delta_t lim;

  // Modular subtraction read as signed gives the shortest arc; 0x8000_0000 is -2^31.
  always_comb begin
    diff = delta_t'(tgt - cur);
    lim  = delta_t'(MAX_STEP);
    if (diff > lim) begin
      step = lim;
    end else if (diff < -lim) begin
      step = -lim;
    end else begin
      step = diff;
    end
  end

endmodule

// File: rtl/jnt_step_gen.sv
// Joint step generator: tracks commanded angles and walks them toward an
// absolute target in clamped increments. Define STEP_CNT_EN to add step_cnt.
module jnt_step_gen
  import jnt_pkg::*;
#(
  parameter logic [31:0] MAX_STEP  = DEFAULT_MAX_STEP,
  parameter logic [31:0] INIT_JNT0 = 32'd0,
  parameter logic [31:0] INIT_JNT1 = 32'd0,
  parameter logic [31:0] INIT_JNT2 = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tgt_valid,
  output logic        tgt_ready,
  input  logic [31:0] tgt_jnt_0,
  input  logic [31:0] tgt_jnt_1,
  input  logic [31:0] tgt_jnt_2,
  output logic        step_valid,
  input  logic        step_ready,
  output logic [31:0] step_jnt_0,
  output logic [31:0] step_jnt_1,
  output logic [31:0] step_jnt_2,
  output logic [31:0] cur_jnt_0,
  output logic [31:0] cur_jnt_1,
  output logic [31:0] cur_jnt_2,
  input  logic        abort,
  output logic        busy,
  output logic        done
`ifdef STEP_CNT_EN
  ,
  output logic [15:0] step_cnt
`endif
);

  state_t      state;
  state_t      state_nxt;

  logic [31:0] tgt_in [3];
  logic [31:0] tgt_q  [3];
  logic [31:0] cur_q  [3];
  logic [31:0] step_q [3];
  logic [31:0] step_c [3];

  logic        accept;
  logic        step_fire;
  logic        load_step;
  logic        all_zero;

  assign tgt_in[0] = tgt_jnt_0;
  assign tgt_in[1] = tgt_jnt_1;
  assign tgt_in[2] = tgt_jnt_2;

  for (genvar g = 0; g < 3; g++) begin : g_clamp
    jnt_step_clamp #(.MAX_STEP(MAX_STEP)) u_clamp (
      .tgt  (tgt_q[g]),
      .cur  (cur_q[g]),
      .step (step_c[g])
    );
  end

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both high. tgt_ready is high only in IDLE; step_valid holds with stable
  // data until step_ready, and drops without a transfer only on abort/reset.
  assign accept    = (state == IDLE) && tgt_valid;
  assign step_fire = (state == EMIT) && step_ready;
  assign all_zero  = (step_c[0] == 32'd0) && (step_c[1] == 32'd0) && (step_c[2] == 32'd0);
  assign load_step = (state == CALC) && !abort && !all_zero;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (tgt_valid) state_nxt = CALC;
      CALC: begin
        if (abort)         state_nxt = IDLE;
        else if (all_zero) state_nxt = DONE;
        else               state_nxt = EMIT;
      end
      EMIT: begin
        if (abort)           state_nxt = IDLE;
        else if (step_ready) state_nxt = CALC;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur_q[0] <= INIT_JNT0;
      cur_q[1] <= INIT_JNT1;
      cur_q[2] <= INIT_JNT2;
      for (int i = 0; i < 3; i++) begin
        tgt_q[i]  <= 32'd0;
        step_q[i] <= 32'd0;
      end
    end else begin
      state <= state_nxt;
      for (int i = 0; i < 3; i++) begin
        if (accept)    tgt_q[i]  <= tgt_in[i];
        if (load_step) step_q[i] <= step_c[i];
        // An abort coinciding with the handshake still commits the step.
        if (step_fire) cur_q[i]  <= cur_q[i] + step_q[i];
      end
    end
  end

  assign tgt_ready  = (state == IDLE);
  assign step_valid = (state == EMIT);
  assign busy       = (state == CALC) || (state == EMIT);
  assign done       = (state == DONE);

  assign step_jnt_0 = step_q[0];
  assign step_jnt_1 = step_q[1];
  assign step_jnt_2 = step_q[2];
  assign cur_jnt_0  = cur_q[0];
  assign cur_jnt_1  = cur_q[1];
  assign cur_jnt_2  = cur_q[2];

`ifdef STEP_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else if (accept) begin
      cnt_q <= 16'd0;
    end else if (step_fire && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign step_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_jnt_step_gen.sv
// Directed bench for jnt_step_gen: a table of moves with hand-computed first
// steps and step counts, plus sequences for backpressure, abort and reset.
module tb_jnt_step_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [31:0] tgt_jnt_0, tgt_jnt_1, tgt_jnt_2;
  logic        step_valid;
  logic        step_ready;
  logic [31:0] step_jnt_0, step_jnt_1, step_jnt_2;
  logic [31:0] cur_jnt_0, cur_jnt_1, cur_jnt_2;
  logic        abort;
  logic        busy;
  logic        done;
`ifdef STEP_CNT_EN
  logic [15:0] step_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] tgt0, tgt1, tgt2;
    logic [31:0] f0, f1, f2;
    int          n_steps;
  } vec_t;

  vec_t vecs [5];

  jnt_step_gen #(
    .MAX_STEP  (32'h0100_0000),
    .INIT_JNT0 (32'd0),
    .INIT_JNT1 (32'd0),
    .INIT_JNT2 (32'd0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_jnt_0  (tgt_jnt_0),
    .tgt_jnt_1  (tgt_jnt_1),
    .tgt_jnt_2  (tgt_jnt_2),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .step_jnt_0 (step_jnt_0),
    .step_jnt_1 (step_jnt_1),
    .step_jnt_2 (step_jnt_2),
    .cur_jnt_0  (cur_jnt_0),
    .cur_jnt_1  (cur_jnt_1),
    .cur_jnt_2  (cur_jnt_2),
    .abort      (abort),
    .busy       (busy),
    .done       (done)
`ifdef STEP_CNT_EN
    ,
    .step_cnt   (step_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tgt(input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    tgt_valid = 1'b1;
    tgt_jnt_0 = t0;
    tgt_jnt_1 = t1;
    tgt_jnt_2 = t2;
  endtask

  // Issue one target from IDLE with step_ready high and follow the move to done.
  task automatic run_vec(input vec_t v, input int idx);
    int  nsteps;
    int  last_cyc;
    bit  got_done;
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive_tgt(v.tgt0, v.tgt1, v.tgt2);
    tick();
    tgt_valid = 1'b0;
    chk({tag, " calc tgt_ready"}, 32'(tgt_ready), 32'd0);
    tick();
    if (v.n_steps == 0) begin
      chk({tag, " zero done"}, 32'(done), 32'd1);
      chk({tag, " zero step_valid"}, 32'(step_valid), 32'd0);
    end else begin
      chk({tag, " first step_valid"}, 32'(step_valid), 32'd1);
      chk({tag, " first step0"}, step_jnt_0, v.f0);
      chk({tag, " first step1"}, step_jnt_1, v.f1);
      chk({tag, " first step2"}, step_jnt_2, v.f2);
    end
    nsteps   = 0;
    last_cyc = 0;
    got_done = 1'b0;
    for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
      if (step_valid) begin
        if (nsteps > 0 && (cyc - last_cyc) != 2) begin
          chk({tag, " step spacing"}, 32'(cyc - last_cyc), 32'd2);
        end
        last_cyc = cyc;
        nsteps++;
      end
      if (done) got_done = 1'b1;
      else tick();
    end
    chk({tag, " done seen"}, 32'(got_done), 32'd1);
    chk({tag, " step count"}, 32'(nsteps), 32'(v.n_steps));
    chk({tag, " cur0"}, cur_jnt_0, v.tgt0);
    chk({tag, " cur1"}, cur_jnt_1, v.tgt1);
    chk({tag, " cur2"}, cur_jnt_2, v.tgt2);
`ifdef STEP_CNT_EN
    chk({tag, " step_cnt"}, 32'(step_cnt), 32'(v.n_steps));
`endif
    tick();
    chk({tag, " back idle"}, 32'({tgt_ready, busy, done}), 32'b100);
  endtask

  initial begin
    vecs[0] = '{32'hFF00_0000, 32'h0080_0000, 32'h8000_0000,
                32'hFF00_0000, 32'h0080_0000, 32'hFF00_0000, 128};
    vecs[1] = '{32'h0200_0000, 32'h0080_0000, 32'h8000_0000,
                32'h0100_0000, 32'h0000_0000, 32'h0000_0000, 3};
    vecs[2] = '{32'h0200_0000, 32'h0080_0000, 32'h8000_0000,
                32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0};
    vecs[3] = '{32'h0200_0050, 32'hFF7F_FFFF, 32'h8123_4567,
                32'h0000_0050, 32'hFF00_0000, 32'h0100_0000, 2};
    vecs[4] = '{32'h0300_0050, 32'hFE7F_FFFF, 32'h8123_4567,
                32'h0100_0000, 32'hFF00_0000, 32'h0000_0000, 1};

    reset      = 1'b1;
    tgt_valid  = 1'b0;
    step_ready = 1'b1;
    abort      = 1'b0;
    tgt_jnt_0  = '0;
    tgt_jnt_1  = '0;
    tgt_jnt_2  = '0;
    tick();
    tick();
    chk("rst tgt_ready", 32'(tgt_ready), 32'd1);
    chk("rst step_valid", 32'(step_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst step0", step_jnt_0, 32'd0);
    chk("rst step1", step_jnt_1, 32'd0);
    chk("rst step2", step_jnt_2, 32'd0);
    chk("rst cur0", cur_jnt_0, 32'd0);
    chk("rst cur1", cur_jnt_1, 32'd0);
    chk("rst cur2", cur_jnt_2, 32'd0);
`ifdef STEP_CNT_EN
    chk("rst step_cnt", 32'(step_cnt), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // simple 3-step move from zero, then back to zero before the table
    run_vec('{32'h0300_0000, 32'd0, 32'd0, 32'h0100_0000, 32'd0, 32'd0, 3}, 99);
    run_vec('{32'd0, 32'd0, 32'd0, 32'hFF00_0000, 32'd0, 32'd0, 3}, 98);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // backpressure: one (0,0,1) step held for several cycles
    step_ready = 1'b0;
    drive_tgt(32'h0300_0050, 32'hFE7F_FFFF, 32'h8123_4568);
    tick();
    tgt_valid = 1'b0;
    tick();
    chk("bp valid", 32'(step_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp hold valid", 32'(step_valid), 32'd1);
      chk("bp hold step0", step_jnt_0, 32'd0);
      chk("bp hold step2", step_jnt_2, 32'd1);
      chk("bp hold cur2", cur_jnt_2, 32'h8123_4567);
    end
    step_ready = 1'b1;
    tick();
    chk("bp commit cur2", cur_jnt_2, 32'h8123_4568);
    chk("bp commit valid", 32'(step_valid), 32'd0);
    tick();
    chk("bp done", 32'(done), 32'd1);
    tick();

    // abort in EMIT without handshake
    step_ready = 1'b0;
    drive_tgt(32'h0400_0050, 32'hFE7F_FFFF, 32'h8123_4568);
    tick();
    tgt_valid = 1'b0;
    tick();
    chk("ab0 valid", 32'(step_valid), 32'd1);
    chk("ab0 step0", step_jnt_0, 32'h0100_0000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab0 state", 32'({tgt_ready, step_valid, busy, done}), 32'b1000);
    chk("ab0 cur0", cur_jnt_0, 32'h0300_0050);
    tick();
    chk("ab0 no done", 32'({step_valid, done}), 32'b00);

    // abort together with the handshake: step is committed
    drive_tgt(32'h0400_0050, 32'hFE7F_FFFF, 32'h8123_4568);
    tick();
    tgt_valid = 1'b0;
    tick();
    chk("ab1 valid", 32'(step_valid), 32'd1);
    abort      = 1'b1;
    step_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab1 state", 32'({tgt_ready, step_valid, busy, done}), 32'b1000);
    chk("ab1 cur0", cur_jnt_0, 32'h0400_0050);
    tick();
    chk("ab1 no done", 32'({step_valid, done}), 32'b00);

    // zero move, with a different target offered while busy
    drive_tgt(32'h0400_0050, 32'hFE7F_FFFF, 32'h8123_4568);
    tick();
    tgt_jnt_0 = 32'h0500_0050;
    chk("zm busy", 32'({tgt_ready, busy}), 32'b01);
    tick();
    tgt_valid = 1'b0;
    chk("zm done", 32'({done, step_valid}), 32'b10);
    tick();
    chk("zm idle", 32'({tgt_ready, busy, done}), 32'b100);
    chk("zm cur0", cur_jnt_0, 32'h0400_0050);
    tick();
    chk("zm not queued", 32'({busy, step_valid}), 32'b00);

    // reset in the middle of a move
    step_ready = 1'b0;
    drive_tgt(32'h0500_0050, 32'hFE7F_FFFF, 32'h8123_4568);
    tick();
    tgt_valid = 1'b0;
    tick();
    chk("mr valid", 32'(step_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr state", 32'({tgt_ready, step_valid, busy, done}), 32'b1000);
    chk("mr cur0", cur_jnt_0, 32'd0);
    chk("mr cur2", cur_jnt_2, 32'd0);
    chk("mr step0", step_jnt_0, 32'd0);
    tick();
    chk("mr quiet", 32'({step_valid, done}), 32'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
